// File: rtl/mac_pkg.sv
// Shared types and default parameter values for the row dot-product engine.
package mac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } mac_state_e;

  localparam int unsigned DEF_LANES    = 2;
  localparam int unsigned DEF_VEC_LEN  = 784;
  localparam int unsigned DEF_ROWS     = 10;
  localparam int unsigned DEF_PIXEL_W  = 8;
  localparam int unsigned DEF_WEIGHT_W = 16;
  localparam int unsigned DEF_OUT_W    = 16;

  // Address/index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v <= 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One multiply lane: zero-extended pixel times signed weight, forced to zero when masked.
module mac_lane
  import mac_pkg::*;
#(
  parameter int unsigned PIXEL_W  = DEF_PIXEL_W,
  parameter int unsigned WEIGHT_W = DEF_WEIGHT_W
) (
  input  logic                              en_i,
  input  logic [PIXEL_W-1:0]                pixel_i,
  input  logic [WEIGHT_W-1:0]               weight_i,
  output logic signed [PIXEL_W+WEIGHT_W:0]  product_o
);

  localparam int unsigned PR_W = PIXEL_W + WEIGHT_W + 1;

  logic signed [PR_W-1:0] pix_s;
  logic signed [PR_W-1:0] wgt_s;

  assign pix_s     = {{(WEIGHT_W + 1){1'b0}}, pixel_i};
  assign wgt_s     = {{(PIXEL_W + 1){weight_i[WEIGHT_W-1]}}, weight_i};
  assign product_o = en_i ? pix_s * wgt_s : '0;

endmodule

// File: rtl/mac_row_engine.sv
// Row dot-product engine: LANES parallel MACs over one-cycle synchronous pixel/weight memories.
// Define MAC_ROW_SATURATE_EN to clamp row_result to the signed OUT_W range instead of wrapping.
module mac_row_engine
  import mac_pkg::*;
#(
  parameter int unsigned LANES    = DEF_LANES,
  parameter int unsigned VEC_LEN  = DEF_VEC_LEN,
  parameter int unsigned ROWS     = DEF_ROWS,
  parameter int unsigned PIXEL_W  = DEF_PIXEL_W,
  parameter int unsigned WEIGHT_W = DEF_WEIGHT_W,
  parameter int unsigned OUT_W    = DEF_OUT_W
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic                                            start,
  input  logic                                            all_rows,
  input  logic [clog2_min1(ROWS)-1:0]                     row_select,
  output logic [LANES*clog2_min1(VEC_LEN)-1:0]            pixel_addr,
  input  logic [LANES*PIXEL_W-1:0]                        pixel_data,
  output logic [LANES*clog2_min1(ROWS*VEC_LEN)-1:0]       weight_addr,
  input  logic [LANES*WEIGHT_W-1:0]                       weight_data,
  output logic                                            busy,
  output logic                                            done_row,
  output logic                                            done_all,
  output logic [clog2_min1(ROWS)-1:0]                     row_index,
  output logic [OUT_W-1:0]                                row_result
);

  localparam int unsigned PA_W  = clog2_min1(VEC_LEN);
  localparam int unsigned WA_W  = clog2_min1(ROWS * VEC_LEN);
  localparam int unsigned RI_W  = clog2_min1(ROWS);
  localparam int unsigned ITER  = (VEC_LEN + LANES - 1) / LANES;
  localparam int unsigned IT_W  = clog2_min1(ITER);
  localparam int unsigned PR_W  = PIXEL_W + WEIGHT_W + 1;
  localparam int unsigned ACC_W = PIXEL_W + WEIGHT_W + $clog2(VEC_LEN) + 1;

  mac_state_e                state_q;
  logic [IT_W-1:0]           iter_q;
  logic [RI_W-1:0]           row_q;
  logic                      all_rows_q;
  logic                      data_vld_q;
  logic [LANES-1:0]          lane_vld_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   acc_d;
  logic                      busy_q;
  logic                      done_row_q;
  logic                      done_all_q;
  logic [RI_W-1:0]           row_index_q;
  logic [OUT_W-1:0]          row_result_q;

  logic [LANES-1:0]          lane_ok;
  logic signed [ACC_W-1:0]   lane_sum;
  logic signed [PR_W-1:0]    prod [LANES];
  logic [OUT_W-1:0]          result_fmt;
  logic                      row_sel_ok;

  assign row_sel_ok = (32'(row_select) < ROWS);

  // Addresses are driven only in RUN; lanes past the vector end stay at address 0.
  always_comb begin
    pixel_addr  = '0;
    weight_addr = '0;
    lane_ok     = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if (state_q == ST_RUN && (32'(iter_q) * LANES + k) < VEC_LEN) begin
        lane_ok[k]                    = 1'b1;
        pixel_addr[k*PA_W +: PA_W]    = PA_W'(32'(iter_q) * LANES + k);
        weight_addr[k*WA_W +: WA_W]   = WA_W'(32'(row_q) * VEC_LEN + 32'(iter_q) * LANES + k);
      end
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(
      .PIXEL_W  (PIXEL_W),
      .WEIGHT_W (WEIGHT_W)
    ) u_lane (
      .en_i      (lane_vld_q[g]),
      .pixel_i   (pixel_data[g*PIXEL_W +: PIXEL_W]),
      .weight_i  (weight_data[g*WEIGHT_W +: WEIGHT_W]),
      .product_o (prod[g])
    );
  end

  always_comb begin
    lane_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lane_sum = lane_sum + {{(ACC_W - PR_W){prod[k][PR_W-1]}}, prod[k]};
    end
    acc_d = acc_q + lane_sum;
  end

`ifdef MAC_ROW_SATURATE_EN
  localparam logic signed [ACC_W-1:0] SAT_HI = {{(ACC_W - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = ~SAT_HI;

  always_comb begin
    result_fmt = acc_q[OUT_W-1:0];
    if (acc_q > SAT_HI) begin
      result_fmt = SAT_HI[OUT_W-1:0];
    end else if (acc_q < SAT_LO) begin
      result_fmt = SAT_LO[OUT_W-1:0];
    end
  end
`else
  assign result_fmt = acc_q[OUT_W-1:0];
`endif

  // Memory data lags the address by one cycle, so lane masks ride along in lane_vld_q
  // and the final iteration is accumulated on the DRAIN->DONE edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      iter_q       <= '0;
      row_q        <= '0;
      all_rows_q   <= 1'b0;
      data_vld_q   <= 1'b0;
      lane_vld_q   <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
      done_row_q   <= 1'b0;
      done_all_q   <= 1'b0;
      row_index_q  <= '0;
      row_result_q <= '0;
    end else begin
      done_row_q <= 1'b0;
      done_all_q <= 1'b0;
      if (data_vld_q) begin
        acc_q <= acc_d;
      end
      unique case (state_q)
        ST_IDLE: begin
          if (start && (all_rows || row_sel_ok)) begin
            state_q    <= ST_RUN;
            row_q      <= all_rows ? '0 : row_select;
            all_rows_q <= all_rows;
            iter_q     <= '0;
            acc_q      <= '0;
            busy_q     <= 1'b1;
          end
        end
        ST_RUN: begin
          lane_vld_q <= lane_ok;
          data_vld_q <= 1'b1;
          if (iter_q == IT_W'(ITER - 1)) begin
            state_q <= ST_DRAIN;
          end else begin
            iter_q <= iter_q + IT_W'(1);
          end
        end
        ST_DRAIN: begin
          data_vld_q <= 1'b0;
          state_q    <= ST_DONE;
        end
        ST_DONE: begin
          done_row_q   <= 1'b1;
          row_index_q  <= row_q;
          row_result_q <= result_fmt;
          if (all_rows_q && row_q != RI_W'(ROWS - 1)) begin
            state_q <= ST_RUN;
            row_q   <= row_q + RI_W'(1);
            iter_q  <= '0;
            acc_q   <= '0;
          end else begin
            done_all_q <= 1'b1;
            busy_q     <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy       = busy_q;
  assign done_row   = done_row_q;
  assign done_all   = done_all_q;
  assign row_index  = row_index_q;
  assign row_result = row_result_q;

endmodule

// File: doc/mac_row_engine.md
MAC_ROW_ENGINE -- requirements
Module: mac_row_engine

Interface
REQ-001 SHALL have parameter LANES, default 2, parallel multiply lanes (1..8).
REQ-002 SHALL have parameter VEC_LEN, default 784, elements per row dot product.
REQ-003 SHALL have parameter ROWS, default 10, number of weight rows.
REQ-004 SHALL have parameter PIXEL_W, default 8, unsigned pixel width.
REQ-005 SHALL have parameter WEIGHT_W, default 16, signed two's-complement weight width.
REQ-006 SHALL have parameter OUT_W, default 16, signed result width.
REQ-007 SHALL use one clock; reset is synchronous and active-high.
REQ-008 SHALL have port clk  in  1  rising-edge clock.
REQ-009 SHALL have port rst  in  1  synchronous active-high reset.
REQ-010 SHALL have port start  in  1  request pulse, sampled only in IDLE.
REQ-011 SHALL have port all_rows  in  1  sampled with start; 1 = compute rows 0..ROWS-1 back to back.
REQ-012 SHALL have port row_select  in  clog2(ROWS)  row for single-row mode.
REQ-013 SHALL have port pixel_addr  out  LANES x clog2(VEC_LEN)  per-lane pixel read address.
REQ-014 SHALL have port pixel_data  in  LANES x PIXEL_W  per-lane pixel read data.
REQ-015 SHALL have port weight_addr  out  LANES x clog2(ROWS*VEC_LEN)  per-lane weight read address.
REQ-016 SHALL have port weight_data  in  LANES x WEIGHT_W  per-lane weight read data.
REQ-017 SHALL have ports busy, done_row, done_all  out  1 each  status and one-cycle completion pulses.
REQ-018 SHALL have ports row_index  out  clog2(ROWS)  and row_result  out  OUT_W  identifying and carrying the finished row.

Function
REQ-019 SHALL implement states IDLE, RUN, DRAIN, DONE; IDLE->RUN on accepted start; RUN->DRAIN after ITER = ceil(VEC_LEN/LANES) address cycles; DRAIN->DONE after one cycle; DONE->RUN (next row, all_rows mode, rows remaining) else DONE->IDLE.
REQ-020 SHALL, in RUN iteration j, drive lane k with element index i = j*LANES+k, pixel_addr = i, weight_addr = row*VEC_LEN + i.
REQ-021 SHALL treat both memories as one-cycle synchronous read: data for iteration j arrives and is accumulated one cycle later.
REQ-022 SHALL mask lane contribution to zero when i >= VEC_LEN (tail iteration), driving that lane's addresses to 0.
REQ-023 SHALL form each product as zero-extended pixel times signed weight and accumulate in an internal ACC_W = PIXEL_W+WEIGHT_W+clog2(VEC_LEN)+1 signed accumulator, which never overflows.
REQ-024 SHALL clear the accumulator at entry to RUN for every row.
REQ-025 SHALL pulse done_row exactly ITER+2 clock edges after the edge that entered RUN for that row, with row_index and row_result valid in that cycle and held until the next row's done_row or reset.
REQ-026 SHALL pulse done_all coincident with done_row of the last row in all_rows mode, and coincident with done_row in single-row mode.
REQ-027 SHALL hold busy high in RUN, DRAIN and DONE, low in IDLE.
REQ-028 SHALL ignore start while busy, and ignore start in single-row mode when row_select >= ROWS (stays IDLE, no pulses).
REQ-029 SHALL, with start and rst high on the same edge, give rst priority.

Reset
REQ-030 SHALL on rst return to IDLE from any state, abandoning any row, and drive busy=0, done_row=0, done_all=0, row_index=0, row_result=0, all addresses=0.

Configuration
REQ-031 SHALL, when macro MAC_ROW_SATURATE_EN is defined, saturate the accumulator to the signed OUT_W range [-2^(OUT_W-1), 2^(OUT_W-1)-1] when forming row_result.
REQ-032 SHALL, when MAC_ROW_SATURATE_EN is undefined, output the low OUT_W bits of the accumulator (wrap).

Structure
REQ-033 SHALL place the state enum type and default parameter constants in shared package mac_pkg.
REQ-034 SHALL instantiate LANES copies of sub-module mac_lane (combinational mask-and-multiply of one pixel/weight pair).

Verification
REQ-035 SHALL cover: defaults, all pixels 1, all weights 1, row 0 -> row_result 784, done_row 394 edges after RUN entry.
REQ-036 SHALL cover: lane 0 weights 1, lane 1 weights 0, row 1 -> row_result 392, row_index 1.
REQ-037 SHALL cover: LANES=3, VEC_LEN=784, all ones -> 784 (tail masking, ITER=262).
REQ-038 SHALL cover: pixels 255, weights 0x7FFF -> 32767 with MAC_ROW_SATURATE_EN; low 16 bits of 255*32767*784 without.
REQ-039 SHALL cover: all_rows=1, weight of row r = r -> ten done_row pulses, row_result 784*r, done_all with row 9.
REQ-040 SHALL cover: rst asserted mid-RUN -> next cycle IDLE, all outputs 0; start during busy -> ignored.
